// File: rtl/demux1to5_buf_pkg.sv
// rtl/demux1to5_buf_pkg.sv - shared constants and helpers for the 1-to-5 distributor
package demux_pkg;

    localparam int NUM_SLOTS = 5;
    localparam int SEL_W     = 3;

    localparam int SLOT_A = 0;
    localparam int SLOT_B = 1;
    localparam int SLOT_C = 2;
    localparam int SLOT_D = 3;
    localparam int SLOT_E = 4;

    // Codes 0..4 address a slot; 5..7 are error codes.
    function automatic logic sel_is_valid(input logic [SEL_W-1:0] sel);
        return (sel <= SEL_W'(SLOT_E));
    endfunction

    function automatic logic [SEL_W-1:0] count_ones(input logic [NUM_SLOTS-1:0] v);
        logic [SEL_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            c = c + {{(SEL_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/demux1to5_buf_if.sv
// rtl/demux1to5_buf_if.sv - producer/consumer bus of the 1-to-5 distributor
// Signals: in_valid/in_ready/in_sel/in_data (producer handshake),
//          out_valid/out_data0..4/out_ack (five consumer slots),
//          occupancy, sel_err/err_clr, err_count (only with DEMUX_ERRCNT_EN).
// master: the environment (producer + consumers); slave: the distributor.
interface demux1to5_buf_if #(
    parameter int DATA_W = 32
);
    import demux_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [SEL_W-1:0]     in_sel;
    logic [DATA_W-1:0]    in_data;
    logic [NUM_SLOTS-1:0] out_valid;
    logic [DATA_W-1:0]    out_data0;
    logic [DATA_W-1:0]    out_data1;
    logic [DATA_W-1:0]    out_data2;
    logic [DATA_W-1:0]    out_data3;
    logic [DATA_W-1:0]    out_data4;
    logic [NUM_SLOTS-1:0] out_ack;
    logic [SEL_W-1:0]     occupancy;
    logic                 sel_err;
    logic                 err_clr;
`ifdef DEMUX_ERRCNT_EN
    logic [7:0]           err_count;
`endif

    modport master (
        output in_valid, in_sel, in_data, out_ack, err_clr,
        input  in_ready, out_valid, out_data0, out_data1, out_data2,
               out_data3, out_data4, occupancy, sel_err
`ifdef DEMUX_ERRCNT_EN
        , input err_count
`endif
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ack, err_clr,
        output in_ready, out_valid, out_data0, out_data1, out_data2,
               out_data3, out_data4, occupancy, sel_err
`ifdef DEMUX_ERRCNT_EN
        , output err_count
`endif
    );

endinterface

// File: rtl/demux1to5_buf_slot.sv
// rtl/demux1to5_buf_slot.sv - single-entry output slot (load/ack/valid/data)
// Ports: clk, reset_n (async active-low), i_load, i_ack, i_data -> o_valid, o_data.
// A load wins over an ack in the same cycle: the old word is consumed and replaced.
module demux_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic              i_ack,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ack) begin
            // Data is deliberately left in place; consumers qualify with valid.
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/demux1to5_buf.sv
// rtl/demux1to5_buf.sv - registered 1-to-5 distributor with per-slot hold-until-ack
// Ports: clk, reset_n (async active-low), bus (demux1to5_buf_if.slave).
// Selector codes 5..7 are accepted, discarded, and latched into sticky sel_err.
// Optional macro DEMUX_ERRCNT_EN adds an 8-bit saturating error counter (err_count).
module demux1to5_buf
    import demux_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input logic             clk,
    input logic             reset_n,
    demux1to5_buf_if.slave  bus
);

    logic [NUM_SLOTS-1:0] w_valid;
    logic [NUM_SLOTS-1:0] w_slot_free;
    logic [NUM_SLOTS-1:0] w_load;
    logic [NUM_SLOTS-1:0] w_valid_next;
    logic                 w_sel_valid;
    logic                 w_target_free;
    logic                 w_ready;
    logic                 w_xfer;
    logic                 w_bad_xfer;
    logic [DATA_W-1:0]    w_data [NUM_SLOTS];
    logic [SEL_W-1:0]     r_occupancy;
    logic                 r_sel_err;

    assign w_sel_valid = sel_is_valid(bus.in_sel);

    always_comb begin
        w_slot_free   = ~w_valid | bus.out_ack;
        w_target_free = 1'b0;
        w_load        = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (bus.in_sel == SEL_W'(i)) w_target_free = w_slot_free[i];
        end
        // Invalid codes are always taken so a bad producer cannot stall the bus.
        w_ready = reset_n && (!w_sel_valid || w_target_free);
        w_xfer  = bus.in_valid && w_ready;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_load[i] = w_xfer && (bus.in_sel == SEL_W'(i));
        end
        w_valid_next = w_load | (w_valid & ~bus.out_ack);
    end

    assign w_bad_xfer = w_xfer && !w_sel_valid;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        demux_slot #(.DATA_W(DATA_W)) u_slot (
            .clk     (clk),
            .reset_n (reset_n),
            .i_load  (w_load[g]),
            .i_ack   (bus.out_ack[g]),
            .i_data  (bus.in_data),
            .o_valid (w_valid[g]),
            .o_data  (w_data[g])
        );
    end

    // Occupancy tracks the post-edge valid vector so it never lags out_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_occupancy <= '0;
            r_sel_err   <= 1'b0;
        end else begin
            r_occupancy <= count_ones(w_valid_next);
            if (w_bad_xfer)       r_sel_err <= 1'b1;
            else if (bus.err_clr) r_sel_err <= 1'b0;
        end
    end

`ifdef DEMUX_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_count <= '0;
        end else if (bus.err_clr) begin
            r_err_count <= w_bad_xfer ? 8'd1 : 8'd0;
        end else if (w_bad_xfer && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign bus.err_count = r_err_count;
`endif

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = w_valid;
    assign bus.out_data0 = w_data[SLOT_A];
    assign bus.out_data1 = w_data[SLOT_B];
    assign bus.out_data2 = w_data[SLOT_C];
    assign bus.out_data3 = w_data[SLOT_D];
    assign bus.out_data4 = w_data[SLOT_E];
    assign bus.occupancy = r_occupancy;
    assign bus.sel_err   = r_sel_err;

endmodule

// File: tb/tb_demux1to5_buf.sv
// tb/tb_demux1to5_buf.sv - directed self-checking bench for demux1to5_buf
module tb_demux1to5_buf;

    logic clk;
    logic reset_n;
    int   n_pass;
    int   n_total;

    demux1to5_buf_if #(.DATA_W(32)) bus ();

    demux1to5_buf #(.DATA_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_sel   = 3'd0;
        bus.in_data  = 32'h0;
        bus.out_ack  = 5'b0;
        bus.err_clr  = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset_n      = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1234_5678;
        step();
        step();
        n_total++; if (bus.out_valid !== 5'b0) $display("FAIL rst_valid got %b exp %b", bus.out_valid, 5'b0); else n_pass++;
        n_total++; if (bus.occupancy !== 3'd0) $display("FAIL rst_occ got %0d exp 0", bus.occupancy); else n_pass++;
        n_total++; if (bus.sel_err !== 1'b0) $display("FAIL rst_err got %b exp 0", bus.sel_err); else n_pass++;
        n_total++; if (bus.out_data0 !== 32'h0) $display("FAIL rst_data0 got %h exp 0", bus.out_data0); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", bus.in_ready); else n_pass++;
        idle();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        bus.in_valid = 1'b1;
        bus.in_sel   = 3'd2;
        bus.in_data  = 32'hDEAD_BEEF;
        #1;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL single_ready got %b exp 1", bus.in_ready); else n_pass++;
        step();
        idle();
        n_total++; if (bus.out_valid !== 5'b00100) $display("FAIL single_valid got %b exp 00100", bus.out_valid); else n_pass++;
        n_total++; if (bus.out_data2 !== 32'hDEAD_BEEF) $display("FAIL single_data2 got %h exp deadbeef", bus.out_data2); else n_pass++;
        n_total++; if (bus.occupancy !== 3'd1) $display("FAIL single_occ got %0d exp 1", bus.occupancy); else n_pass++;
        bus.out_ack = 5'b00100;
        step();
        idle();
        n_total++; if (bus.out_valid !== 5'b0) $display("FAIL ack_valid got %b exp 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.occupancy !== 3'd0) $display("FAIL ack_occ got %0d exp 0", bus.occupancy); else n_pass++;
        n_total++; if (bus.out_data2 !== 32'hDEAD_BEEF) $display("FAIL ack_hold got %h exp deadbeef", bus.out_data2); else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = 3'(i);
            bus.in_data  = 32'(i + 1);
            step();
        end
        idle();
        n_total++; if (bus.out_valid !== 5'b11111) $display("FAIL fill_valid got %b exp 11111", bus.out_valid); else n_pass++;
        n_total++; if (bus.occupancy !== 3'd5) $display("FAIL fill_occ got %0d exp 5", bus.occupancy); else n_pass++;
        n_total++; if (bus.out_data0 !== 32'd1) $display("FAIL fill_d0 got %h exp 1", bus.out_data0); else n_pass++;
        n_total++; if (bus.out_data1 !== 32'd2) $display("FAIL fill_d1 got %h exp 2", bus.out_data1); else n_pass++;
        n_total++; if (bus.out_data3 !== 32'd4) $display("FAIL fill_d3 got %h exp 4", bus.out_data3); else n_pass++;
        n_total++; if (bus.out_data4 !== 32'd5) $display("FAIL fill_d4 got %h exp 5", bus.out_data4); else n_pass++;
        bus.in_valid = 1'b1;
        bus.in_sel   = 3'd3;
        bus.in_data  = 32'h0000_0077;
        #1;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL full_ready got %b exp 0", bus.in_ready); else n_pass++;
        step();
        n_total++; if (bus.out_data3 !== 32'd4) $display("FAIL full_hold got %h exp 4", bus.out_data3); else n_pass++;
        n_total++; if (bus.occupancy !== 3'd5) $display("FAIL full_occ got %0d exp 5", bus.occupancy); else n_pass++;
    endtask

    task automatic test_ack_load();
        bus.in_valid = 1'b1;
        bus.in_sel   = 3'd3;
        bus.in_data  = 32'hA5A5_A5A5;
        bus.out_ack  = 5'b01000;
        #1;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL al_ready got %b exp 1", bus.in_ready); else n_pass++;
        step();
        idle();
        n_total++; if (bus.out_valid !== 5'b11111) $display("FAIL al_valid got %b exp 11111", bus.out_valid); else n_pass++;
        n_total++; if (bus.out_data3 !== 32'hA5A5_A5A5) $display("FAIL al_data3 got %h exp a5a5a5a5", bus.out_data3); else n_pass++;
        n_total++; if (bus.occupancy !== 3'd5) $display("FAIL al_occ got %0d exp 5", bus.occupancy); else n_pass++;
        bus.out_ack = 5'b11111;
        step();
        idle();
        n_total++; if (bus.occupancy !== 3'd0) $display("FAIL drain_occ got %0d exp 0", bus.occupancy); else n_pass++;
    endtask

    task automatic test_sel_err();
        bus.in_valid = 1'b1;
        bus.in_sel   = 3'd6;
        bus.in_data  = 32'hBAD0_0006;
        #1;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL err_ready got %b exp 1", bus.in_ready); else n_pass++;
        step();
        idle();
        n_total++; if (bus.sel_err !== 1'b1) $display("FAIL err_set got %b exp 1", bus.sel_err); else n_pass++;
        n_total++; if (bus.out_valid !== 5'b0) $display("FAIL err_noslot got %b exp 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.occupancy !== 3'd0) $display("FAIL err_occ got %0d exp 0", bus.occupancy); else n_pass++;
`ifdef DEMUX_ERRCNT_EN
        n_total++; if (bus.err_count !== 8'd1) $display("FAIL cnt_first got %0d exp 1", bus.err_count); else n_pass++;
        bus.in_valid = 1'b1;
        bus.in_sel   = 3'd5;
        step();
        idle();
        n_total++; if (bus.err_count !== 8'd2) $display("FAIL cnt_second got %0d exp 2", bus.err_count); else n_pass++;
`endif
        bus.in_valid = 1'b1;
        bus.in_sel   = 3'd7;
        bus.err_clr  = 1'b1;
        step();
        idle();
        n_total++; if (bus.sel_err !== 1'b1) $display("FAIL err_setwins got %b exp 1", bus.sel_err); else n_pass++;
`ifdef DEMUX_ERRCNT_EN
        n_total++; if (bus.err_count !== 8'd1) $display("FAIL cnt_clrinc got %0d exp 1", bus.err_count); else n_pass++;
`endif
        bus.err_clr = 1'b1;
        step();
        idle();
        n_total++; if (bus.sel_err !== 1'b0) $display("FAIL err_clr got %b exp 0", bus.sel_err); else n_pass++;
`ifdef DEMUX_ERRCNT_EN
        n_total++; if (bus.err_count !== 8'd0) $display("FAIL cnt_clr got %0d exp 0", bus.err_count); else n_pass++;
`endif
    endtask

    task automatic test_mixed();
        bus.in_valid = 1'b1;
        bus.in_sel   = 3'd0;
        bus.in_data  = 32'h0000_0010;
        step();
        bus.in_sel   = 3'd4;
        bus.in_data  = 32'h0000_0014;
        step();
        bus.in_sel   = 3'd1;
        bus.in_data  = 32'h0000_0011;
        bus.out_ack  = 5'b00001;
        step();
        idle();
        n_total++; if (bus.out_valid !== 5'b10010) $display("FAIL mix_valid got %b exp 10010", bus.out_valid); else n_pass++;
        n_total++; if (bus.occupancy !== 3'd2) $display("FAIL mix_occ got %0d exp 2", bus.occupancy); else n_pass++;
        n_total++; if (bus.out_data1 !== 32'h11) $display("FAIL mix_d1 got %h exp 11", bus.out_data1); else n_pass++;
        n_total++; if (bus.out_data4 !== 32'h14) $display("FAIL mix_d4 got %h exp 14", bus.out_data4); else n_pass++;
    endtask

    task automatic test_async_reset();
        bus.in_valid = 1'b1;
        bus.in_sel   = 3'd2;
        bus.in_data  = 32'h0000_0012;
        step();
        idle();
        n_total++; if (bus.occupancy !== 3'd3) $display("FAIL pre_rst_occ got %0d exp 3", bus.occupancy); else n_pass++;
        bus.in_valid = 1'b1;
        bus.in_sel   = 3'd0;
        #2;
        reset_n = 1'b0;
        #1;
        n_total++; if (bus.out_valid !== 5'b0) $display("FAIL arst_valid got %b exp 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.occupancy !== 3'd0) $display("FAIL arst_occ got %0d exp 0", bus.occupancy); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL arst_ready got %b exp 0", bus.in_ready); else n_pass++;
        idle();
        step();
        reset_n = 1'b1;
        step();
        n_total++; if (bus.out_valid !== 5'b0) $display("FAIL post_rst_valid got %b exp 0", bus.out_valid); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset_n = 1'b0;
        idle();
        test_reset();
        test_single();
        test_fill();
        test_ack_load();
        test_sel_err();
        test_mixed();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
